vlsu_l1_burst_port: RTL and testbench
=====================================

# vlsu_l1_burst_port

Burst-to-beat load port between Ara's address generator and a multi-ported L1 D$. It splits each accepted burst into full-width beats, spreads them round-robin over `NrPorts` D$ read ports, and tracks up to `MaxOutstanding` in-flight beats in a reorder buffer (ROB). Beat data is returned in order to the vector load unit with valid/ready backpressure. It replaces the single-port load path, which was gated by a queue-full flag, with credit-based issue and out-of-order completion across ports.

## Interface
- `NrPorts`, 2: number of D$ read ports, 1..4.
- `DataWidth`, 64: beat width in bits, power of two, at least 32.
- `AddrWidth`, 64: physical address width.
- `MaxOutstanding`, 8: ROB entries, power of two, 2..32.
- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_addr_i` in AddrWidth: burst base address. Low log2(DataWidth/8) bits are ignored and treated as zero.
- `req_len_i` in 8: number of beats minus 1.
- `req_valid_i` / `req_ready_o` in/out 1: burst handshake.
- `dc_req_o` out NrPorts: per-port request valid. Held until granted.
- `dc_addr_o` out NrPorts×AddrWidth: per-port beat address.
- `dc_gnt_i` in NrPorts: per-port grant.
- `dc_rvalid_i` in NrPorts: per-port read-data valid. Data returns in grant order within a port.
- `dc_rdata_i` in NrPorts×DataWidth: per-port read data.
- `rdata_o` out DataWidth: in-order beat data.
- `rvalid_o` / `rready_i` out/in 1: result handshake.
- `rlast_o` out 1: marks the final beat of a burst, qualified by `rvalid_o`.
- `flush_i` in 1: abandon the current burst.
- `busy_o` out 1: high in any state other than IDLE.

## Operation
- **IDLE.** `req_ready_o` is 1. On `req_valid_i` the block latches the address and the count (`req_len_i`+1) and goes to ISSUE.
- **ISSUE, allocation.** At most one beat is allocated per cycle, and only when both hold:
  - the round-robin target port has no pending request;
  - the ROB has a free slot (count < MaxOutstanding).
- **ISSUE, per allocated beat.**
  - Beat address = base + i·(DataWidth/8), modulo 2^AddrWidth.
  - The ROB slot at `alloc_ptr` is marked busy.
  - The port register is loaded with the address and the slot index.
  - The round-robin pointer advances, wrapping at NrPorts.
  - If the target port is occupied, the block stalls on that port; it does not skip to another port.
- **Grant.** On `dc_gnt_i[p]` with `dc_req_o[p]`, the slot index is pushed into the tag FIFO of port p and the port is freed. A new beat may be allocated to port p in the following cycle.
- **Response.** On `dc_rvalid_i[p]`:
  - the tag FIFO of port p is popped;
  - the data is written into that ROB slot and the slot is marked filled.
  - All ports may respond in the same cycle.
- **Output.**
  - `rvalid_o` is asserted when the head slot is filled.
  - On `rvalid_o & rready_i` the head pointer increments and the count decrements.
  - `rlast_o` is 1 when the head beat is beat number count−1.
- After the last allocation the block goes to **DRAIN**. When the ROB is empty and the last beat has been accepted, it returns to IDLE.
- **FLUSH.**
  - Entered from ISSUE or DRAIN when `flush_i` is 1.
  - Ungranted port requests are dropped immediately.
  - `rvalid_o` is forced to 0.
  - Outstanding responses are consumed and discarded.
  - The block returns to IDLE once every tag FIFO is empty. ROB pointers and count are cleared on that exit.
  - `flush_i` in IDLE has no effect.
- **Simultaneous events.** In the same cycle as a fill, allocate and pop are all legal, and the count updates net (+1 −1). A fill to the head slot makes `rvalid_o` high on the next cycle.

## Timing
- All outputs are registered, except `req_ready_o`, which is decoded from the state.
- Reset values:
  - `req_ready_o` = 1;
  - `dc_req_o` = 0, `dc_addr_o` = 0;
  - `rvalid_o` = 0, `rlast_o` = 0, `rdata_o` = 0;
  - `busy_o` = 0;
  - state = IDLE, all pointers and counts = 0.
- Burst acceptance in cycle t gives the first `dc_req_o` in cycle t+1.
- `dc_rvalid_i` for the head slot in cycle t gives `rvalid_o` in cycle t+1.
- Peak throughput is 1 beat per cycle.
- Tag FIFO depth is MaxOutstanding, so a tag FIFO never overflows.
- `rst_i` asserted mid-burst returns the block to IDLE on the next edge. Responses arriving after reset are ignored.

## Structure
- `ara_pkg` gains:
  - `l1_burst_state_e` {IDLE, ISSUE, DRAIN, FLUSH};
  - the ROB index typedef, `logic [$clog2(MaxOutstanding)-1:0]`.
- Sub-module `vlsu_l1_tag_fifo`: a per-port FIFO of ROB indices with synchronous active-high reset, instantiated NrPorts times.

## Test plan
- **Single port, no stall.** NrPorts=1, addr 0x1000, len 3, grant every cycle, responses 2 cycles after grant → `dc_addr_o` = 0x1000, 0x1008, 0x1010, 0x1018; 4 beats out in order; `rlast_o` on the 4th beat.
- **Out-of-order completion.** NrPorts=2, len 7, port 1 responds 5 cycles before port 0 → output order is still beats 0..7.
- **ROB full.** MaxOutstanding=4, len 15, responses withheld → exactly 4 grants, then `dc_req_o` stays 0 until one head beat is consumed.
- **Backpressure.** `rready_i`=0 for 10 cycles with 2 beats filled → `rvalid_o` held with stable `rdata_o`, and no beat is lost.
- **Flush mid-burst.** Flush after 3 grants with 1 beat returned → `rvalid_o`=0; the block stays in FLUSH until 2 more responses arrive, then goes IDLE with `req_ready_o`=1.
- **Address wrap.** AddrWidth=32, addr 0xFFFF_FFF8, len 1 → addresses 0xFFFF_FFF8, 0x0000_0000.

Source files
------------

// File: rtl/ara_pkg.sv
// Shared types for the Ara vector load path: L1 burst port state and ROB index.
package ara_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FLUSH
    } l1_burst_state_e;

    localparam int unsigned L1MaxOutstanding = 8;

    typedef logic [$clog2(L1MaxOutstanding)-1:0] l1_rob_idx_t;

endpackage

// File: rtl/vlsu_l1_tag_fifo.sv
// Per-port FIFO of ROB slot indices, pushed on grant and popped on read-data valid.
module vlsu_l1_tag_fifo #(
    parameter int unsigned Depth    = 8,
    parameter int unsigned IdxWidth = 3
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                push_i,
    input  logic [IdxWidth-1:0] tag_i,
    input  logic                pop_i,
    output logic [IdxWidth-1:0] tag_o,
    output logic                empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [IdxWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [PtrW:0]       cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + (PtrW+1)'(push_i) - (PtrW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= tag_i;
    end

    always_comb begin
        tag_o   = mem_q[rd_ptr_q];
        empty_o = (cnt_q == '0);
    end

endmodule

// File: rtl/vlsu_l1_burst_port.sv
// Burst-to-beat load port: round-robin issue over D$ read ports, in-order
// return through a reorder buffer with valid/ready backpressure.
module vlsu_l1_burst_port
    import ara_pkg::*;
#(
    parameter int unsigned NrPorts        = 2,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [AddrWidth-1:0]           req_addr_i,
    input  logic [7:0]                     req_len_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    output logic [NrPorts-1:0]             dc_req_o,
    output logic [NrPorts*AddrWidth-1:0]   dc_addr_o,
    input  logic [NrPorts-1:0]             dc_gnt_i,
    input  logic [NrPorts-1:0]             dc_rvalid_i,
    input  logic [NrPorts*DataWidth-1:0]   dc_rdata_i,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           rvalid_o,
    input  logic                           rready_i,
    output logic                           rlast_o,
    input  logic                           flush_i,
    output logic                           busy_o
);

    localparam int unsigned IdxW      = $clog2(MaxOutstanding);
    localparam int unsigned CntW      = IdxW + 1;
    localparam int unsigned PortW     = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int unsigned BeatBytes = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(BeatBytes);

    typedef logic [IdxW-1:0] rob_idx_t;

    l1_burst_state_e state_q, state_d;

    logic [AddrWidth-1:0]  next_addr_q;
    logic [7:0]            total_m1_q;
    logic [8:0]            alloc_cnt_q;
    logic [7:0]            out_cnt_q;
    logic [PortW-1:0]      rr_q;
    rob_idx_t              alloc_ptr_q;
    rob_idx_t              head_ptr_q;
    logic [CntW-1:0]       count_q;
    logic [MaxOutstanding-1:0] rob_filled_q;
    logic [DataWidth-1:0]  rob_data_q [MaxOutstanding];

    logic [NrPorts-1:0]    port_req_q;
    logic [AddrWidth-1:0]  port_addr_q [NrPorts];
    rob_idx_t              port_tag_q  [NrPorts];

    logic [NrPorts-1:0]    fifo_push;
    logic [NrPorts-1:0]    fifo_pop;
    logic [NrPorts-1:0]    fifo_empty;
    rob_idx_t              fifo_tag [NrPorts];

    logic                  accept;
    logic                  alloc;
    logic                  last_alloc;
    logic                  pop;
    logic                  flush_take;
    logic                  flush_done;
    logic [8:0]            cur_cnt;
    logic [7:0]            cur_total;
    logic [AddrWidth-1:0]  cur_addr;

    for (genvar p = 0; p < NrPorts; p++) begin : g_tag_fifo
        vlsu_l1_tag_fifo #(
            .Depth   (MaxOutstanding),
            .IdxWidth(IdxW)
        ) i_tag_fifo (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .push_i (fifo_push[p]),
            .tag_i  (port_tag_q[p]),
            .pop_i  (fifo_pop[p]),
            .tag_o  (fifo_tag[p]),
            .empty_o(fifo_empty[p])
        );
    end

    // The first beat is allocated in the acceptance cycle itself, straight from the request.
    always_comb begin
        accept     = (state_q == IDLE) && req_valid_i;
        cur_cnt    = (state_q == IDLE) ? '0 : alloc_cnt_q;
        cur_total  = (state_q == IDLE) ? req_len_i : total_m1_q;
        cur_addr   = (state_q == IDLE) ? {req_addr_i[AddrWidth-1:OffW], {OffW{1'b0}}} : next_addr_q;
        alloc      = !port_req_q[rr_q] && (count_q < CntW'(MaxOutstanding)) &&
                     (accept || ((state_q == ISSUE) && !flush_i));
        last_alloc = alloc && (cur_cnt == {1'b0, cur_total});
        pop        = rvalid_o && rready_i;
        flush_take = flush_i && ((state_q == ISSUE) || (state_q == DRAIN));
        flush_done = (state_q == FLUSH) && (&fifo_empty);
        for (int unsigned p = 0; p < NrPorts; p++) begin
            fifo_push[p] = dc_gnt_i[p] && port_req_q[p];
            fifo_pop[p]  = dc_rvalid_i[p] && !fifo_empty[p];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (req_valid_i) state_d = last_alloc ? DRAIN : ISSUE;
            ISSUE: if (flush_i) state_d = FLUSH;
                   else if (last_alloc) state_d = DRAIN;
            DRAIN: if (flush_i) state_d = FLUSH;
                   else if (pop && rlast_o) state_d = IDLE;
            FLUSH: if (&fifo_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        rvalid_o    = (state_q != FLUSH) && rob_filled_q[head_ptr_q];
        rlast_o     = rvalid_o && (out_cnt_q == total_m1_q);
        rdata_o     = rob_data_q[head_ptr_q];
        dc_req_o    = port_req_q;
        dc_addr_o   = '0;
        for (int unsigned p = 0; p < NrPorts; p++) begin
            dc_addr_o[p*AddrWidth +: AddrWidth] = port_addr_q[p];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            next_addr_q  <= '0;
            total_m1_q   <= '0;
            alloc_cnt_q  <= '0;
            out_cnt_q    <= '0;
            rr_q         <= '0;
            alloc_ptr_q  <= '0;
            head_ptr_q   <= '0;
            count_q      <= '0;
            rob_filled_q <= '0;
            port_req_q   <= '0;
            for (int unsigned i = 0; i < MaxOutstanding; i++) rob_data_q[i] <= '0;
            for (int unsigned p = 0; p < NrPorts; p++) begin
                port_addr_q[p] <= '0;
                port_tag_q[p]  <= '0;
            end
        end else begin
            if (accept) begin
                total_m1_q <= req_len_i;
                out_cnt_q  <= '0;
            end
            if (accept || alloc) begin
                alloc_cnt_q <= cur_cnt + 9'(alloc);
                next_addr_q <= alloc ? cur_addr + AddrWidth'(BeatBytes) : cur_addr;
            end
            for (int unsigned p = 0; p < NrPorts; p++) begin
                if (fifo_push[p]) port_req_q[p] <= 1'b0;
            end
            if (flush_take) port_req_q <= '0;
            if (alloc) begin
                port_req_q[rr_q]  <= 1'b1;
                port_addr_q[rr_q] <= cur_addr;
                port_tag_q[rr_q]  <= alloc_ptr_q;
                alloc_ptr_q       <= alloc_ptr_q + 1'b1;
                rr_q              <= (rr_q == PortW'(NrPorts - 1)) ? '0 : rr_q + 1'b1;
            end
            // Responses drained during FLUSH are dropped rather than filling the ROB.
            for (int unsigned p = 0; p < NrPorts; p++) begin
                if (fifo_pop[p] && (state_q != FLUSH)) begin
                    rob_data_q[fifo_tag[p]]   <= dc_rdata_i[p*DataWidth +: DataWidth];
                    rob_filled_q[fifo_tag[p]] <= 1'b1;
                end
            end
            if (pop) begin
                rob_filled_q[head_ptr_q] <= 1'b0;
                head_ptr_q               <= head_ptr_q + 1'b1;
                out_cnt_q                <= out_cnt_q + 8'd1;
            end
            count_q <= count_q + CntW'(alloc) - CntW'(pop);
            if (flush_done) begin
                head_ptr_q   <= '0;
                alloc_ptr_q  <= '0;
                count_q      <= '0;
                rob_filled_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vlsu_l1_burst_port.sv
// Randomized bench for vlsu_l1_burst_port with a D$ responder and an in-order beat scoreboard.
module tb_vlsu_l1_burst_port;

    localparam int unsigned NP = 2;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned MO = 4;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [AW-1:0]     req_addr_i;
    logic [7:0]        req_len_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [NP-1:0]     dc_req_o;
    logic [NP*AW-1:0]  dc_addr_o;
    logic [NP-1:0]     dc_gnt_i;
    logic [NP-1:0]     dc_rvalid_i;
    logic [NP*DW-1:0]  dc_rdata_i;
    logic [DW-1:0]     rdata_o;
    logic              rvalid_o;
    logic              rready_i;
    logic              rlast_o;
    logic              flush_i;
    logic              busy_o;

    vlsu_l1_burst_port #(
        .NrPorts       (NP),
        .DataWidth     (DW),
        .AddrWidth     (AW),
        .MaxOutstanding(MO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_addr_i (req_addr_i),
        .req_len_i  (req_len_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .dc_req_o   (dc_req_o),
        .dc_addr_o  (dc_addr_o),
        .dc_gnt_i   (dc_gnt_i),
        .dc_rvalid_i(dc_rvalid_i),
        .dc_rdata_i (dc_rdata_i),
        .rdata_o    (rdata_o),
        .rvalid_o   (rvalid_o),
        .rready_i   (rready_i),
        .rlast_o    (rlast_o),
        .flush_i    (flush_i),
        .busy_o     (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: expected per-port beat addresses/data and in-order output stream.
    logic [AW-1:0] exp_paddr [NP][$];
    logic [DW-1:0] exp_pdata [NP][$];
    logic [DW-1:0] pend_data [NP][$];
    int            pend_due  [NP][$];
    logic [DW-1:0] exp_out_data [$];
    logic          exp_out_last [$];

    int model_rr = 0;
    int cyc = 0;
    int burst_id = 0;
    int burst_grants = 0;
    int grant_limit = 1 << 30;
    int resp_budget = 1 << 30;
    int gnt_pct = 100;
    int rdy_pct = 100;
    int dly_min [NP];
    int dly_max [NP];

    initial forever @(posedge clk_i) cyc++;

    function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a, input int id);
        logic [15:0] idv;
        idv = id[15:0];
        return {a ^ 32'hC0DE_5EED, idv, a[15:0]};
    endfunction

    task automatic model_burst(input logic [AW-1:0] addr, input int len);
        logic [AW-1:0] a;
        a = {addr[AW-1:3], 3'b000};
        burst_id++;
        burst_grants = 0;
        for (int i = 0; i <= len; i++) begin
            int p;
            p = (model_rr + i) % NP;
            exp_paddr[p].push_back(a);
            exp_pdata[p].push_back(data_of(a, burst_id));
            exp_out_data.push_back(data_of(a, burst_id));
            exp_out_last.push_back(i == len);
            a = a + 32'd8;
        end
        model_rr = (model_rr + len + 1) % NP;
    endtask

    task automatic clear_model();
        for (int p = 0; p < NP; p++) begin
            exp_paddr[p].delete();
            exp_pdata[p].delete();
            pend_data[p].delete();
            pend_due[p].delete();
        end
        exp_out_data.delete();
        exp_out_last.delete();
        model_rr = 0;
    endtask

    // D$ responder: random grants, per-port in-order responses after a random delay.
    initial begin
        dc_gnt_i    = '0;
        dc_rvalid_i = '0;
        dc_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            for (int p = 0; p < NP; p++) begin
                logic g;
                logic rv;
                g  = 1'b0;
                rv = 1'b0;
                if (!rst_i && dc_req_o[p] && burst_grants < grant_limit &&
                    $urandom_range(99) < gnt_pct) begin
                    g = 1'b1;
                    burst_grants++;
                    check_eq("grant_expected", 64'(exp_paddr[p].size() != 0), 64'd1);
                    if (exp_paddr[p].size() != 0) begin
                        check_eq($sformatf("grant_addr_p%0d", p), 64'(dc_addr_o[p*AW +: AW]),
                                 64'(exp_paddr[p].pop_front()));
                        pend_data[p].push_back(exp_pdata[p].pop_front());
                        pend_due[p].push_back(cyc + int'($urandom_range(dly_max[p], dly_min[p])));
                    end
                end
                dc_gnt_i[p] = g;
                dc_rdata_i[p*DW +: DW] = {$urandom, $urandom};
                if (!rst_i && pend_due[p].size() != 0 && pend_due[p][0] <= cyc && resp_budget > 0) begin
                    rv = 1'b1;
                    resp_budget--;
                    dc_rdata_i[p*DW +: DW] = pend_data[p].pop_front();
                    void'(pend_due[p].pop_front());
                end
                dc_rvalid_i[p] = rv;
            end
        end
    end

    // Result sink: random backpressure, every accepted beat checked in order.
    initial begin
        rready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            rready_i = !rst_i && ($urandom_range(99) < rdy_pct);
            if (rvalid_o && rready_i) begin
                check_eq("beat_expected", 64'(exp_out_data.size() != 0), 64'd1);
                if (exp_out_data.size() != 0) begin
                    check_eq("rdata", rdata_o, exp_out_data.pop_front());
                    check_eq("rlast", 64'(rlast_o), 64'(exp_out_last.pop_front()));
                end
            end
        end
    end

    task automatic set_delays(input int min0, input int max0, input int min1, input int max1);
        dly_min[0] = min0; dly_max[0] = max0;
        dly_min[1] = min1; dly_max[1] = max1;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready_o), 64'd1);
        check_eq({tag, "_dc_req"},    64'(dc_req_o), 64'd0);
        check_eq({tag, "_dc_addr"},   64'(dc_addr_o), 64'd0);
        check_eq({tag, "_rvalid"},    64'(rvalid_o), 64'd0);
        check_eq({tag, "_rlast"},     64'(rlast_o), 64'd0);
        check_eq({tag, "_rdata"},     rdata_o, 64'd0);
        check_eq({tag, "_busy"},      64'(busy_o), 64'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk_i);
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        repeat (2) @(negedge clk_i);
        clear_model();
        rst_i = 1'b0;
    endtask

    task automatic send_burst(input logic [AW-1:0] addr, input int len);
        int p0;
        logic [AW-1:0] a0;
        @(negedge clk_i);
        check_eq("ready_before_req", 64'(req_ready_o), 64'd1);
        p0 = model_rr;
        a0 = {addr[AW-1:3], 3'b000};
        model_burst(addr, len);
        req_valid_i = 1'b1;
        req_addr_i  = addr;
        req_len_i   = 8'(len);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check_eq("first_req", 64'(dc_req_o[p0]), 64'd1);
        check_eq("first_addr", 64'(dc_addr_o[p0*AW +: AW]), 64'(a0));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while ((busy_o || exp_out_data.size() != 0) && n < budget);
        check_eq("idle_in_time", 64'(n < budget), 64'd1);
        check_eq("beats_left", 64'(exp_out_data.size()), 64'd0);
        check_eq("grants_left", 64'(exp_paddr[0].size() + exp_paddr[1].size()), 64'd0);
    endtask

    task automatic random_bursts(input int n);
        for (int b = 0; b < n; b++) begin
            gnt_pct = int'($urandom_range(100, 30));
            rdy_pct = int'($urandom_range(100, 30));
            set_delays(1, int'($urandom_range(6, 1)), 1, int'($urandom_range(6, 1)));
            send_burst($urandom, (b % 5 == 4) ? int'($urandom_range(40, 16)) : int'($urandom_range(15)));
            wait_idle(3000);
        end
    endtask

    initial begin
        logic [DW-1:0] held;
        int n;
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_addr_i  = '0;
        req_len_i   = '0;
        flush_i     = 1'b0;
        set_delays(2, 2, 2, 2);
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check_reset_values("reset");

        // Basic burst with unaligned base, fixed 2-cycle response delay
        gnt_pct = 100; rdy_pct = 100;
        send_burst(32'h0000_1005, 3);
        wait_idle(200);

        random_bursts(12);

        // Port 1 answers much sooner than port 0
        gnt_pct = 100; rdy_pct = 100;
        set_delays(8, 10, 1, 2);
        send_burst(32'h0000_2000, 7);
        wait_idle(500);

        // ROB full: responses withheld, then backpressure on filled beats
        set_delays(1, 2, 1, 2);
        resp_budget = 0; rdy_pct = 0;
        send_burst(32'h0000_3000, 15);
        repeat (20) @(negedge clk_i);
        check_eq("robfull_grants", 64'(burst_grants), 64'(MO));
        check_eq("robfull_no_req", 64'(dc_req_o), 64'd0);
        resp_budget = 1 << 30;
        repeat (8) @(negedge clk_i);
        check_eq("robfull_grants_hold", 64'(burst_grants), 64'(MO));
        check_eq("bp_rvalid", 64'(rvalid_o), 64'd1);
        held = rdata_o;
        repeat (10) @(negedge clk_i);
        check_eq("bp_rvalid_held", 64'(rvalid_o), 64'd1);
        check_eq("bp_rdata_stable", rdata_o, held);
        check_eq("bp_rdata_head", rdata_o, exp_out_data[0]);
        rdy_pct = 100;
        wait_idle(500);

        // Address wrap at the top of a 32-bit space
        send_burst(32'hFFFF_FFF8, 1);
        wait_idle(200);

        // Flush mid-burst: 3 grants, 1 response, then 2 outstanding to drain
        set_delays(1, 1, 1, 1);
        grant_limit = 3; resp_budget = 0; rdy_pct = 0;
        send_burst(32'h0000_4000, 7);
        repeat (10) @(negedge clk_i);
        check_eq("flush_grants", 64'(burst_grants), 64'd3);
        resp_budget = 1;
        repeat (5) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check_eq("flush_rvalid", 64'(rvalid_o), 64'd0);
        check_eq("flush_dc_req", 64'(dc_req_o), 64'd0);
        check_eq("flush_busy", 64'(busy_o), 64'd1);
        repeat (5) @(negedge clk_i);
        check_eq("flush_wait_busy", 64'(busy_o), 64'd1);
        check_eq("flush_wait_ready", 64'(req_ready_o), 64'd0);
        resp_budget = 2;
        n = 0;
        while (busy_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check_eq("flush_exit_in_time", 64'(n < 50), 64'd1);
        check_eq("flush_exit_ready", 64'(req_ready_o), 64'd1);
        check_eq("flush_exit_rvalid", 64'(rvalid_o), 64'd0);
        grant_limit = 1 << 30; resp_budget = 1 << 30; rdy_pct = 100;
        reset_dut();
        check_reset_values("post_flush");

        // Reset in the middle of a long burst
        set_delays(1, 4, 1, 4);
        send_burst(32'h0000_5000, 20);
        repeat (6) @(negedge clk_i);
        reset_dut();
        check_reset_values("mid_reset");

        random_bursts(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
